// File: rtl/mux5_pkg.sv
// Shared types and helpers for the 5-way round-robin select arbiter.
package mux5_pkg;
  localparam int unsigned NREQ  = 5;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Mod-5 increment: 4 wraps to 0 by explicit compare.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] k);
    return (k == SEL_W'(NREQ - 1)) ? '0 : SEL_W'(k + 1'b1);
  endfunction
endpackage

// File: rtl/mux5_rr_arbiter_if.sv
// Requester-side bus of the 5:1 select arbiter: requests, data words, grant and selected word.
interface mux5_rr_arbiter_if #(
  parameter int unsigned DATA_W = 1
);
  logic [4:0]          req;
  logic [5*DATA_W-1:0] i;
  logic [4:0]          gnt;
  logic [2:0]          s;
  logic                valid;
  logic [DATA_W-1:0]   y;

  modport master (output req, output i, input gnt, input s, input valid, input y);
  modport slave  (input req, input i, output gnt, output s, output valid, output y);
endinterface

// File: rtl/rr_pick5.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod 5.
module rr_pick5
  import mux5_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx,
  output logic [NREQ-1:0]  onehot
);
  logic [SEL_W-1:0] cand;
  logic             found;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int unsigned n = 0; n < NREQ; n++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = next_idx(cand);
    end
    onehot = any ? (NREQ'(1) << idx) : '0;
  end
endmodule

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter for the shared 5:1 select lane, with bounded hold under contention.
module mux5_rr_arbiter
  import mux5_pkg::*;
#(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  mux5_rr_arbiter_if.slave   bus
);
  localparam int unsigned HC_W      = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  state_t           state;
  logic [NREQ-1:0]  gnt_q;
  logic [SEL_W-1:0] s_q;
  logic [SEL_W-1:0] ptr;
  logic             valid_q;
  logic [HC_W-1:0]  hold_cnt;

  logic [NREQ-1:0]  others;
  logic [NREQ-1:0]  pick_req;
  logic [SEL_W-1:0] pick_ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [NREQ-1:0]  pick_onehot;
  logic             owner_req;
  logic             at_limit;
  logic             do_release;

  // Release decision and picker feed: full req from IDLE, competitors past the owner on release.
  always_comb begin
    others     = bus.req & ~gnt_q;
    owner_req  = |(bus.req & gnt_q);
    at_limit   = (MAX_HOLD != 0) && (hold_cnt == HC_W'(HOLD_LAST));
    do_release = !owner_req || (at_limit && (|others));
    pick_req   = bus.req;
    pick_ptr   = ptr;
    if (state == ST_GRANT) begin
      pick_req = others;
      pick_ptr = next_idx(s_q);
    end
  end

  rr_pick5 u_pick (
    .req    (pick_req),
    .ptr    (pick_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      s_q      <= '0;
      valid_q  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state    <= ST_GRANT;
            gnt_q    <= pick_onehot;
            s_q      <= pick_idx;
            valid_q  <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (do_release) begin
            ptr      <= next_idx(s_q);
            hold_cnt <= '0;
            if (pick_any) begin
              gnt_q <= pick_onehot;
              s_q   <= pick_idx;
            end else begin
              state   <= ST_IDLE;
              gnt_q   <= '0;
              valid_q <= 1'b0;
            end
          end else if ((MAX_HOLD != 0) && !at_limit) begin
            hold_cnt <= HC_W'(hold_cnt + 1'b1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output lane: word selected by s, forced to zero when no grant is active.
  logic [DATA_W-1:0] words [NREQ];
  for (genvar k = 0; k < NREQ; k++) begin : g_word
    assign words[k] = bus.i[k*DATA_W +: DATA_W];
  end

  assign bus.gnt   = gnt_q;
  assign bus.s     = s_q;
  assign bus.valid = valid_q;
  assign bus.y     = valid_q ? words[s_q] : '0;
endmodule
